bnn_layer_sequencer: RTL and testbench

- Control FSM that runs one fully-connected binary layer on compute_module's weight (W) and activation (X) memory banks.
- For each output neuron it:
  - clears the XNOR-popcount accumulator;
  - streams n_in paired X/W reads;
  - writes the sign-activated result bit back into an X bank.
- Sits between the top-level testbench/host (start/finish) and the compute_module memory and accumulator control pins.

---
 rtl/bnn_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bnn_layer_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_layer_sequencer.sv
// Control FSM for one fully-connected binary layer: clear, stream n_in X/W reads, write sign bit.
// Optional BNN_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter output perf_cycles.
module bnn_layer_sequencer #(
   parameter int W_ADDR_LEN = 20,
   parameter int W_SEL_LEN  = 2,
   parameter int X_ADDR_LEN = 10,
   parameter int X_SEL_LEN  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  start,
   input  logic [X_ADDR_LEN-1:0] n_in,
   input  logic [X_ADDR_LEN-1:0] n_out,
   input  logic [W_ADDR_LEN-1:0] w_base,
   input  logic [W_SEL_LEN-1:0]  w_bank,
   input  logic [X_SEL_LEN-1:0]  in_bank,
   input  logic [X_SEL_LEN-1:0]  out_bank,
   input  logic                  acc_sign,
   output logic [W_ADDR_LEN-1:0] w_addr,
   output logic [W_SEL_LEN-1:0]  w_sel,
   output logic                  w_rq,
   output logic [X_ADDR_LEN-1:0] x_addr,
   output logic [X_SEL_LEN-1:0]  x_sel,
   output logic                  x_rq,
   output logic                  x_wq,
   output logic                  x_wdata,
   output logic                  acc_clr,
   output logic                  acc_en,
   output logic                  busy,
   output logic                  compute_finish
`ifdef BNN_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]           perf_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_READ,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                state, state_nx;
   logic [X_ADDR_LEN-1:0] i_cnt, j_cnt;
   logic [X_ADDR_LEN-1:0] n_in_q, n_out_q;
   logic [W_ADDR_LEN-1:0] w_ptr;
   logic [W_SEL_LEN-1:0]  w_bank_q;
   logic [X_SEL_LEN-1:0]  in_bank_q, out_bank_q;
   logic                  acc_en_q;
   logic                  accept;
   logic                  last_in, last_out;

   assign accept   = en & start & (state == S_IDLE);
   assign last_in  = (i_cnt == n_in_q - 1'b1);
   assign last_out = (j_cnt == n_out_q - 1'b1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         i_cnt      <= '0;
         j_cnt      <= '0;
         n_in_q     <= '0;
         n_out_q    <= '0;
         w_ptr      <= '0;
         w_bank_q   <= '0;
         in_bank_q  <= '0;
         out_bank_q <= '0;
         acc_en_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         // read data returns one cycle after the request, so the gated request lines up with it
         acc_en_q <= w_rq;
         if (accept) begin
            n_in_q     <= n_in;
            n_out_q    <= n_out;
            w_ptr      <= w_base;
            w_bank_q   <= w_bank;
            in_bank_q  <= in_bank;
            out_bank_q <= out_bank;
            j_cnt      <= '0;
         end
         if (en) begin
            case (state)
               S_CLEAR: i_cnt <= '0;
               S_READ: begin
                  w_ptr <= w_ptr + 1'b1;
                  if (!last_in) i_cnt <= i_cnt + 1'b1;
               end
               S_WRITE: if (!last_out) j_cnt <= j_cnt + 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nx = state;
      if (en) begin
         case (state)
            S_IDLE:
               if (start) state_nx = (n_in == '0 || n_out == '0) ? S_DONE : S_CLEAR;
            S_CLEAR: state_nx = S_READ;
            S_READ:  if (last_in) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: state_nx = last_out ? S_DONE : S_CLEAR;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_addr         = '0;
      w_sel          = '0;
      w_rq           = 1'b0;
      x_addr         = '0;
      x_sel          = '0;
      x_rq           = 1'b0;
      x_wq           = 1'b0;
      x_wdata        = 1'b0;
      acc_clr        = 1'b0;
      compute_finish = 1'b0;
      case (state)
         S_CLEAR: acc_clr = en;
         S_READ: begin
            w_rq   = en;
            x_rq   = en;
            w_addr = w_ptr;
            w_sel  = w_bank_q;
            x_addr = i_cnt;
            x_sel  = in_bank_q;
         end
         S_WRITE: begin
            x_wq    = en;
            x_addr  = j_cnt;
            x_sel   = out_bank_q;
            x_wdata = ~acc_sign;
         end
         S_DONE:  compute_finish = en;
         default: ;
      endcase
   end

   assign busy   = (state != S_IDLE);
   assign acc_en = acc_en_q;

`ifdef BNN_SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (accept) begin
         perf_cycles <= '0;
      end else if (busy && en && perf_cycles != '1) begin
         perf_cycles <= perf_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Scoreboard bench for bnn_layer_sequencer: a layer-level model predicts the event stream, a monitor checks it.
module tb_bnn_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst, en, start;
   logic [9:0]  n_in, n_out;
   logic [19:0] w_base;
   logic [1:0]  w_bank, in_bank, out_bank;
   logic        acc_sign;
   logic [19:0] w_addr;
   logic [1:0]  w_sel, x_sel;
   logic [9:0]  x_addr;
   logic        w_rq, x_rq, x_wq, x_wdata, acc_clr, acc_en, busy, compute_finish;

   // sign bit per output neuron, served back to the DUT as if from the accumulator
   logic [1023:0] sign_pat;
   assign acc_sign = sign_pat[x_addr];

   bnn_layer_sequencer #(
      .W_ADDR_LEN(20),
      .W_SEL_LEN (2),
      .X_ADDR_LEN(10),
      .X_SEL_LEN (2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .start(start),
      .n_in(n_in), .n_out(n_out), .w_base(w_base), .w_bank(w_bank),
      .in_bank(in_bank), .out_bank(out_bank), .acc_sign(acc_sign),
      .w_addr(w_addr), .w_sel(w_sel), .w_rq(w_rq),
      .x_addr(x_addr), .x_sel(x_sel), .x_rq(x_rq), .x_wq(x_wq), .x_wdata(x_wdata),
      .acc_clr(acc_clr), .acc_en(acc_en), .busy(busy), .compute_finish(compute_finish)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 clear, 1 read, 2 write, 3 finish
      logic [19:0] wa;
      logic [1:0]  ws;
      logic [9:0]  xa;
      logic [1:0]  xs;
      logic        wd;
      int          act;
      int          accs;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0, errors = 0;
   bit   mon_en = 0, run_active = 0;
   int   act_cnt = 0, acc_cnt = 0, wall_cnt = 0, fin_wall = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic pop_exp(input int k, output exp_t e, output bit ok);
      e = '{default: 0};
      checks++;
      if (sbq.size() == 0) begin
         ok = 0;
         errors++;
         $display("FAIL sb_order got kind %0d want nothing", k);
      end else begin
         e  = sbq.pop_front();
         ok = (e.kind == k);
         if (!ok) begin
            errors++;
            $display("FAIL sb_order got kind %0d want kind %0d", k, e.kind);
         end
      end
   endtask

   // layer-level model: the event list a layer must produce, in order
   task automatic push_layer(input int nin, input int nout, input logic [19:0] base,
                             input logic [1:0] wb, input logic [1:0] ib, input logic [1:0] ob);
      exp_t e;
      e = '{default: 0};
      if (nin == 0 || nout == 0) begin
         e.kind = 3; e.act = 1; e.accs = 0;
         sbq.push_back(e);
         return;
      end
      for (int j = 0; j < nout; j++) begin
         e = '{default: 0};
         e.kind = 0;
         sbq.push_back(e);
         for (int i = 0; i < nin; i++) begin
            e = '{default: 0};
            e.kind = 1;
            e.wa   = base + 20'(j * nin + i);
            e.ws   = wb;
            e.xa   = 10'(i);
            e.xs   = ib;
            sbq.push_back(e);
         end
         e = '{default: 0};
         e.kind = 2; e.xa = 10'(j); e.xs = ob; e.wd = ~sign_pat[j];
         sbq.push_back(e);
      end
      e = '{default: 0};
      e.kind = 3; e.act = nout * (nin + 3) + 1; e.accs = nin * nout;
      sbq.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (mon_en && !rst) begin
         if (run_active) begin
            wall_cnt++;
            if (en) act_cnt++;
            if (acc_en) acc_cnt++;
         end
         chk("busy", busy, run_active);
         if (!en) chk("gated_req", {w_rq, x_rq, x_wq, acc_clr, compute_finish}, 0);
         if (acc_clr) pop_exp(0, e, ok);
         if (w_rq || x_rq) begin
            pop_exp(1, e, ok);
            if (ok) begin
               chk("rd_rq", {w_rq, x_rq}, 2'b11);
               chk("w_addr", w_addr, e.wa);
               chk("w_sel", w_sel, e.ws);
               chk("rd_x_addr", x_addr, e.xa);
               chk("rd_x_sel", x_sel, e.xs);
            end
         end
         if (x_wq) begin
            pop_exp(2, e, ok);
            if (ok) begin
               chk("wr_x_addr", x_addr, e.xa);
               chk("wr_x_sel", x_sel, e.xs);
               chk("x_wdata", x_wdata, e.wd);
            end
         end
         if (compute_finish) begin
            pop_exp(3, e, ok);
            if (ok) begin
               chk("active_cycles", act_cnt, e.act);
               chk("acc_en_count", acc_cnt, e.accs);
            end
            fin_wall   = wall_cnt;
            run_active = 0;
         end
      end
   end

   // mode 0: en held high, 1: random en drops, 2: en low in cycles 4..6 after start
   task automatic run_layer(input int nin, input int nout, input logic [19:0] base,
                            input logic [1:0] wb, input logic [1:0] ib, input logic [1:0] ob,
                            input int mode, input int sp);
      int nominal;
      nominal = (nin == 0 || nout == 0) ? 1 : nout * (nin + 3) + 1;
      if (sp >= 0) sign_pat = 1024'(sp);
      else for (int k = 0; k < 32; k++) sign_pat[k*32 +: 32] = $urandom;
      n_in = 10'(nin); n_out = 10'(nout); w_base = base;
      w_bank = wb; in_bank = ib; out_bank = ob;
      en = 1'b1; start = 1'b1;
      push_layer(nin, nout, base, wb, ib, ob);
      @(posedge clk); #1;
      start = 1'b0;
      act_cnt = 0; acc_cnt = 0; wall_cnt = 0; run_active = 1;
      n_in = 10'($urandom); n_out = 10'($urandom); w_base = 20'($urandom);
      w_bank = 2'($urandom); in_bank = 2'($urandom); out_bank = 2'($urandom);
      for (int c = 0; c < 20000 && run_active; c++) begin
         if (mode == 1) en = ($urandom_range(0, 3) != 0);
         else if (mode == 2) en = !(c >= 3 && c <= 5);
         else en = 1'b1;
         start = ($urandom_range(0, 15) == 0);
         @(posedge clk); #1;
         start = 1'b0;
      end
      en = 1'b1;
      if (run_active) begin
         checks++; errors++;
         $display("FAIL finish_timeout got none want finish");
         run_active = 0;
         sbq.delete();
      end else if (mode == 0) begin
         chk("latency", fin_wall, nominal);
      end else if (mode == 2) begin
         chk("stall_latency", fin_wall, nominal + 3);
      end
   endtask

   task automatic reset_during_write();
      n_in = 10'd4; n_out = 10'd2; w_base = 20'h00200;
      w_bank = 2'd1; in_bank = 2'd2; out_bank = 2'd3;
      sign_pat = '0;
      en = 1'b1; start = 1'b1;
      push_layer(4, 2, 20'h00200, 2'd1, 2'd2, 2'd3);
      @(posedge clk); #1;
      start = 1'b0; act_cnt = 0; acc_cnt = 0; wall_cnt = 0; run_active = 1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (x_wq) break;
      end
      #1;
      chk("rst_saw_write", x_wq, 1'b1);
      rst = 1'b1;
      sbq.delete();
      run_active = 0;
      @(negedge clk);
      chk("rst_outputs", {w_addr, w_sel, w_rq, x_addr, x_sel, x_rq, x_wq, x_wdata,
                          acc_clr, acc_en, busy, compute_finish}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; start = 1'b0;
      n_in = '0; n_out = '0; w_base = '0; w_bank = '0; in_bank = '0; out_bank = '0;
      sign_pat = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {w_addr, w_sel, w_rq, x_addr, x_sel, x_rq, x_wq, x_wdata,
                            acc_clr, acc_en, busy, compute_finish}, 0);
      @(posedge clk); #1;
      rst = 1'b0; en = 1'b1; mon_en = 1;
      @(posedge clk); #1;

      run_layer(4, 2, 20'h00100, 2'd0, 2'd0, 2'd1, 0, 1);
      run_layer(4, 0, 20'h00100, 2'd0, 2'd0, 2'd1, 0, 0);
      run_layer(0, 3, 20'h00100, 2'd0, 2'd0, 2'd1, 0, 0);
      run_layer(4, 1, 20'hFFFFE, 2'd2, 2'd1, 2'd2, 0, -1);
      run_layer(4, 2, 20'h00100, 2'd0, 2'd0, 2'd1, 2, -1);
      reset_during_write();
      run_layer(4, 2, 20'h00100, 2'd0, 2'd0, 2'd1, 0, 2);

      for (int t = 0; t < 40; t++) begin
         logic [19:0] base;
         base = ($urandom_range(0, 3) == 0) ? 20'hFFFF0 + 20'($urandom_range(0, 15))
                                            : 20'($urandom);
         run_layer($urandom_range(0, 12), $urandom_range(0, 5), base,
                   2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 1), -1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      #1;
      chk("sb_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
